// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file writeback control slice.
package regfile_ctrl_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic {
        REQ_LD  = 1'b0,
        REQ_ALU = 1'b1
    } req_id_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared when the register file captures the write.
module wb_scoreboard #(
    parameter int NREG = regfile_ctrl_pkg::NREG,
    parameter int AW   = regfile_ctrl_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_reg,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_reg,
    input  logic [AW-1:0] query_reg1,
    input  logic [AW-1:0] query_reg2,
    output logic          busy1,
    output logic          busy2
);
    import regfile_ctrl_pkg::*;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Clear is applied before set so a same-edge issue keeps the bit high.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (clr_en && clr_reg == AW'(i))
                busy_next[i] = 1'b0;
            if (set_en && set_reg == AW'(i))
                busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign busy1 = busy[query_reg1];
    assign busy2 = busy[query_reg2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
module regfile_wb_arbiter #(
    parameter int NREG = regfile_ctrl_pkg::NREG,
    parameter int AW   = regfile_ctrl_pkg::AW,
    parameter int DW   = regfile_ctrl_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_reg,
    input  logic [DW-1:0] ld_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    input  logic [AW-1:0] query_reg1,
    input  logic [AW-1:0] query_reg2,
    output logic          busy1,
    output logic          busy2,
    output logic          reg_write,
    output logic [AW-1:0] write_reg,
    output logic [DW-1:0] write_data
);
    import regfile_ctrl_pkg::*;

    req_id_t       ptr_q, ptr_d;
    logic          xfer;
    logic [AW-1:0] sel_reg;
    logic [DW-1:0] sel_data;
    logic          do_write;

    // ptr_q names the requester that wins the next contention.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        ptr_d     = ptr_q;
        if (!reset) begin
            if (ld_valid && (!alu_valid || ptr_q == REQ_LD))
                ld_ready = 1'b1;
            else if (alu_valid)
                alu_ready = 1'b1;
        end
        if (ld_ready)
            ptr_d = REQ_ALU;
        else if (alu_ready)
            ptr_d = REQ_LD;
    end

    assign xfer     = ld_ready | alu_ready;
    assign sel_reg  = ld_ready ? ld_reg  : alu_reg;
    assign sel_data = ld_ready ? ld_data : alu_data;
    assign do_write = xfer && (sel_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= REQ_LD;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            ptr_q     <= ptr_d;
            reg_write <= do_write;
            if (do_write) begin
                write_reg  <= sel_reg;
                write_data <= sel_data;
            end
        end
    end

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue_valid),
        .set_reg    (issue_reg),
        .clr_en     (reg_write),
        .clr_reg    (write_reg),
        .query_reg1 (query_reg1),
        .query_reg2 (query_reg2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, issue_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_reg, ld_reg, issue_reg, query_reg1, query_reg2;
    logic [31:0] alu_data, ld_data;
    logic        busy1, busy2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_reg      (ld_reg),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .query_reg1  (query_reg1),
        .query_reg2  (query_reg2),
        .busy1       (busy1),
        .busy2       (busy2),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who was granted last, which registers await a write,
    // and what the write port should show this cycle.
    bit          busy_m [32];
    int          last_grant;     // 0 = load, 1 = ALU
    bit          exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
    int          grant_tick;     // -1 none, 0 load, 1 ALU
    logic        obs_alu_r, obs_ld_r, obs_rw, obs_b1, obs_b2;
    logic [4:0]  obs_wreg;
    logic [31:0] obs_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        last_grant = 1;
        exp_rw     = 1'b0;
        exp_wreg   = '0;
        exp_wdata  = '0;
    endtask

    task automatic tick();
        bit exp_ld_r, exp_alu_r;
        #1;
        exp_ld_r  = !reset && ld_valid && (!alu_valid || last_grant == 1);
        exp_alu_r = !reset && alu_valid && !exp_ld_r;
        obs_alu_r = alu_ready;  obs_ld_r = ld_ready;
        obs_b1    = busy1;      obs_b2   = busy2;
        obs_rw    = reg_write;  obs_wreg = write_reg;  obs_wdata = write_data;
        chk("alu_ready",  obs_alu_r, exp_alu_r);
        chk("ld_ready",   obs_ld_r,  exp_ld_r);
        chk("busy1",      obs_b1,    busy_m[query_reg1]);
        chk("busy2",      obs_b2,    busy_m[query_reg2]);
        chk("reg_write",  obs_rw,    exp_rw);
        chk("write_reg",  obs_wreg,  exp_wreg);
        chk("write_data", obs_wdata, exp_wdata);
        @(posedge clk);
        grant_tick = exp_ld_r ? 0 : (exp_alu_r ? 1 : -1);
        if (reset) begin
            model_reset();
        end else begin
            if (exp_rw) busy_m[exp_wreg] = 1'b0;
            if (issue_valid && issue_reg != 0) busy_m[issue_reg] = 1'b1;
            exp_rw = 1'b0;
            if (grant_tick >= 0) begin
                last_grant = grant_tick;
                if ((grant_tick == 0 ? ld_reg : alu_reg) != 0) begin
                    exp_rw    = 1'b1;
                    exp_wreg  = grant_tick == 0 ? ld_reg  : alu_reg;
                    exp_wdata = grant_tick == 0 ? ld_data : alu_data;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
        alu_reg = '0; ld_reg = '0; issue_reg = '0; query_reg1 = '0; query_reg2 = '0;
        alu_data = '0; ld_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state with both requests pending: no ready may rise.
        alu_valid = 1'b1; ld_valid = 1'b1; query_reg1 = 5'd9; query_reg2 = 5'd5;
        tick();
        chk("reset_no_ready", {obs_alu_r, obs_ld_r}, 2'b00);
        reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        tick();

        // Lone ALU request.
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hDEADBEEF;
        tick();
        chk("t1_alu_ready", obs_alu_r, 1'b1);
        alu_valid = 1'b0;
        tick();
        chk("t1_rw", obs_rw, 1'b1);
        chk("t1_wreg", obs_wreg, 5'd7);
        chk("t1_wdata", obs_wdata, 32'hDEADBEEF);
        tick();
        chk("t1_rw_drop", obs_rw, 1'b0);

        // Sustained contention alternates starting with load.
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA3;
        ld_valid  = 1'b1; ld_reg  = 5'd4; ld_data  = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_ld_grant", obs_ld_r, (i % 2 == 0));
            if (i > 0) chk("rr_rw_stream", obs_rw, 1'b1);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        chk("rr_last_write", obs_wreg, 5'd3);

        // Load to r0: accepted but never written.
        ld_valid = 1'b1; ld_reg = 5'd0; ld_data = 32'h1234;
        tick();
        chk("r0_ld_ready", obs_ld_r, 1'b1);
        ld_valid = 1'b0;
        tick();
        chk("r0_no_write", obs_rw, 1'b0);
        chk("r0_wdata_hold", obs_wdata, 32'hA3);

        // Scoreboard lifetime of r9.
        issue_valid = 1'b1; issue_reg = 5'd9; query_reg1 = 5'd9;
        tick();
        issue_valid = 1'b0;
        tick();
        chk("sb9_set", obs_b1, 1'b1);
        ld_valid = 1'b1; ld_reg = 5'd9; ld_data = 32'h55;
        tick();
        ld_valid = 1'b0;
        tick();
        chk("sb9_during_write", {obs_rw, obs_b1}, 2'b11);
        tick();
        chk("sb9_cleared", obs_b1, 1'b0);

        // Reissue to r5 on the edge its write lands: set wins.
        issue_valid = 1'b1; issue_reg = 5'd5; query_reg2 = 5'd5;
        tick();
        issue_valid = 1'b0; alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h5555;
        tick();
        alu_valid = 1'b0; issue_valid = 1'b1;
        tick();
        chk("sb5_write_cycle", obs_wreg, 5'd5);
        issue_valid = 1'b0;
        tick();
        chk("sb5_set_wins", obs_b2, 1'b1);

        // Reset while a write is registered.
        alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h22;
        tick();
        alu_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_kill_write", obs_rw, 1'b0);
        chk("rst_busy_clear", {obs_b1, obs_b2}, 2'b00);
        alu_valid = 1'b1; ld_valid = 1'b1; alu_reg = 5'd1; ld_reg = 5'd6;
        tick();
        chk("rst_first_ld", {obs_ld_r, obs_alu_r}, 2'b10);
        if (grant_tick == 0) ld_valid = 1'b0; else if (grant_tick == 1) alu_valid = 1'b0;

        // Randomized traffic honouring the hold-until-accepted rule.
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1'b1; alu_reg = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!ld_valid && $urandom_range(0, 2) != 0) begin
                ld_valid = 1'b1; ld_reg = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_reg   = 5'($urandom_range(0, 7));
            query_reg1  = 5'($urandom_range(0, 7));
            query_reg2  = 5'($urandom_range(0, 31));
            reset       = ($urandom_range(0, 59) == 0);
            tick();
            if (grant_tick == 0) ld_valid = 1'b0;
            else if (grant_tick == 1) alu_valid = 1'b0;
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
